// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, reset PC
// and word-address helpers.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Next-fetch-address register: reset, redirect (highest priority after reset)
// or sequential advance by one word.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);

  // PC update with redirect taking precedence over the fetch advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= align_word(RESET_PC);
    end else if (redirect_valid) begin
      pc <= align_word(redirect_pc);
    end else if (advance) begin
      pc <= next_word_addr(pc);
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding-request instruction fetch unit with a one-entry output
// buffer handing instructions to the IF/ID stage.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] PC_4_out,
  output logic [31:0] Instruction_out,
  output logic        fetch_valid
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic         capture;

  // Returned data is discarded whenever a redirect arrives in the same cycle
  assign capture   = (state == FETCH) && imem_ready && !redirect_valid;
  assign imem_addr = pc;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .advance       (capture),
    .pc            (pc)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = FETCH;
    end else begin
      case (state)
        IDLE:    state_next = FETCH;
        FETCH:   state_next = imem_ready ? FULL : FETCH;
        FULL:    state_next = stall ? FULL : FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    imem_req = 1'b0;
    case (state)
      FETCH:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Output buffer: instruction/PC only change on capture, valid drops on consume
  always_ff @(posedge clk) begin
    if (rst) begin
      Instruction_out <= 32'h0000_0000;
      PC_4_out        <= 32'h0000_0000;
      fetch_valid     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_valid     <= 1'b0;
    end else if (capture) begin
      Instruction_out <= imem_rdata;
      PC_4_out        <= next_word_addr(pc);
      fetch_valid     <= 1'b1;
    end else if ((state == FULL) && !stall) begin
      fetch_valid     <= 1'b0;
    end else begin
      fetch_valid     <= fetch_valid;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared each cycle against a transaction-level reference model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] PC_4_out;
  logic [31:0] Instruction_out;
  logic        fetch_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 = settling after reset, 1 = request outstanding,
  // 2 = instruction waiting for downstream.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  int          transfers;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .PC_4_out       (PC_4_out),
    .Instruction_out(Instruction_out),
    .fetch_valid    (fetch_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode  = 0;
      m_pc    = 32'h0000_0000;
      m_instr = 32'h0000_0000;
      m_pc4   = 32'h0000_0000;
      m_valid = 1'b0;
    end else if (redirect_valid) begin
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_mode  = 1;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && imem_ready) begin
      m_instr = imem_rdata;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_mode  = 2;
    end else if (m_mode == 2 && !stall) begin
      transfers++;
      m_valid = 1'b0;
      m_mode  = 1;
    end
  endtask

  task automatic cycle(input bit check, input bit r, input bit rdy, input logic [31:0] data,
                       input bit st, input bit rv, input logic [31:0] rpc);
    rst            = r;
    imem_ready     = rdy;
    imem_rdata     = data;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (check) begin
      chk("imem_req",        {31'd0, imem_req},    {31'd0, (m_mode == 1)});
      chk("imem_addr",       imem_addr,            m_pc);
      chk("fetch_valid",     {31'd0, fetch_valid}, {31'd0, m_valid});
      chk("Instruction_out", Instruction_out,      m_instr);
      chk("PC_4_out",        PC_4_out,             m_pc4);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    transfers = 0;
    m_mode = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);

    // Reset, then free-running fetch with instant memory
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_instr", Instruction_out, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, 32'h1000_0000 + i, 1'b0, 1'b0, 32'h0);
    chk("seq_pc4", PC_4_out, 32'h0000_000C);
    chk("seq_valid", {31'd0, fetch_valid}, 32'd1);

    // Memory wait states, capture of 0x2002_0005, then downstream stall
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'hBAD0_0000, 1'b0, 1'b0, 32'h0);
    chk("wait_req", {31'd0, imem_req}, 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 32'h2002_0005, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 32'hBAD0_0001, 1'b1, 1'b0, 32'h0);
    chk("stall_instr", Instruction_out, 32'h2002_0005);
    chk("stall_pc4", PC_4_out, 32'h0000_0010);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("after_stall_addr", imem_addr, 32'h0000_0010);

    // Redirect collides with returning data
    cycle(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0103);
    chk("redir_valid", {31'd0, fetch_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_instr", Instruction_out, 32'h2002_0005);

    // Wrap of the address space
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc4", PC_4_out, 32'h0000_0000);
    chk("wrap_valid", {31'd0, fetch_valid}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset in the middle of an outstanding request
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    cycle(1'b1, 1'b1, 1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h0000_0400);
    chk("rst_instr", Instruction_out, 32'h0);
    chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("rst_next_req", {31'd0, imem_req}, 32'd1);
    chk("rst_next_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'b1,
            ($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 60),
            $urandom,
            ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 8),
            $urandom);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  instruction memory byte address (word aligned).
REQ-006 imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  instruction word, valid only when imem_ready=1.
REQ-008 stall  input  1  downstream IF/ID stage cannot accept this cycle.
REQ-009 redirect_valid  input  1  branch/jump taken; replace PC.
REQ-010 redirect_pc  input  32  redirect target address.
REQ-011 PC_4_out  output  32  address of buffered instruction + 4.
REQ-012 Instruction_out  output  32  buffered instruction word.
REQ-013 fetch_valid  output  1  PC_4_out/Instruction_out hold a valid instruction.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, FULL; an internal 32-bit pc register SHALL hold the next fetch address.
REQ-015 IDLE: imem_req=0; unconditionally -> FETCH next cycle.
REQ-016 FETCH: imem_req=1, imem_addr=pc; imem_req SHALL stay high until imem_ready=1.
REQ-017 FETCH with imem_ready=1: Instruction_out<=imem_rdata, PC_4_out<=pc+4, fetch_valid<=1, pc<=pc+4, -> FULL.
REQ-018 FULL: imem_req=0; outputs held stable while stall=1.
REQ-019 FULL with stall=0: instruction consumed this cycle; fetch_valid<=0, -> FETCH.
REQ-020 Handshake: an instruction is transferred downstream exactly in cycles with fetch_valid=1 and stall=0.
REQ-021 redirect_valid=1 in any state SHALL take priority over imem_ready and stall: pc<={redirect_pc[31:2],2'b00}, fetch_valid<=0, imem_ready/imem_rdata ignored that cycle, -> FETCH.
REQ-022 imem_addr SHALL equal pc whenever imem_req=0.
REQ-023 pc+4 arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-024 imem_ready asserted in IDLE or FULL SHALL be ignored.
REQ-025 Instruction_out and PC_4_out SHALL NOT change except on the FETCH capture of REQ-017 or on reset.
REQ-026 Latency: with imem_ready=1 on first request cycle and stall=0, one instruction SHALL be delivered every 2 cycles.

Reset
REQ-027 rst=1 at a clock edge SHALL set state=IDLE, pc=RESET_PC, fetch_valid=0, Instruction_out=0, PC_4_out=0; imem_req=0 in the following cycle.
REQ-028 rst SHALL override redirect_valid, stall and imem_ready in the same cycle.
REQ-029 Reset during an outstanding request SHALL abandon it; the first request after reset SHALL use RESET_PC.

Structure
REQ-030 FSM state encoding and the default RESET_PC constant SHALL live in a shared pipeline package.
REQ-031 The pc register with increment/redirect mux SHALL be one sub-module, fetch_pc_reg; FSM and output buffer stay in the top.

Verification
REQ-032 Reset with RESET_PC=0, imem_ready=1, stall=0 -> imem_addr 0x0,0x4,0x8 in successive FETCH cycles; PC_4_out 0x4,0x8,0xC with fetch_valid pulses every 2nd cycle.
REQ-033 imem_ready held low 3 cycles in FETCH -> imem_req high all 3 cycles, imem_addr constant, fetch_valid=0 until capture.
REQ-034 stall=1 for 4 cycles while FULL with Instruction_out=0x2002_0005 -> outputs unchanged, imem_req=0; stall release -> next fetch at PC_4_out.
REQ-035 redirect_valid=1, redirect_pc=0x0000_0103 in same cycle as imem_ready=1 -> data dropped, fetch_valid=0, next imem_addr=0x0000_0100.
REQ-036 pc=0xFFFF_FFFC fetch completes -> PC_4_out=0x0000_0000, next imem_addr=0x0.
REQ-037 rst=1 mid-FETCH with imem_ready=1 -> no capture, all outputs 0, next request at RESET_PC.
